// File: rtl/mips_mem_pkg.sv
// Shared types for the unified instruction/data memory port arbiter.
// Holds the FSM encoding, the timed-out read value, port ids and the latched bus command.
package mips_mem_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      I_ACC = 2'd1,
      D_ACC = 2'd2
   } arb_state_t;

   localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEADBEEF;

   localparam logic PORT_IF = 1'b0;
   localparam logic PORT_D  = 1'b1;

   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
   } mem_cmd_t;

   function automatic arb_state_t acc_state(input logic port);
      return (port == PORT_D) ? D_ACC : I_ACC;
   endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Fetch port, data port and backing-memory bus of the memory port arbiter.
// The arbiter uses the slave view; the pipeline/memory environment uses the master view.
interface mem_port_arbiter_if;

   logic        if_req;
   logic [31:0] if_addr;
   logic [31:0] if_rdata;
   logic        if_ready;

   logic        d_req;
   logic        d_we;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic [31:0] d_rdata;
   logic        d_ready;

   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_ack;
   logic [31:0] mem_rdata;

   logic        bus_err;

   modport slave (
      input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_ack, mem_rdata,
      output if_rdata, if_ready, d_rdata, d_ready,
      output mem_req, mem_we, mem_addr, mem_wdata, bus_err
   );

   modport master (
      output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_ack, mem_rdata,
      input  if_rdata, if_ready, d_rdata, d_ready,
      input  mem_req, mem_we, mem_addr, mem_wdata, bus_err
   );

endinterface

// File: rtl/mem_timeout_ctr.sv
// Counts no-ack cycles of one memory access; expire fires on the edge the count would reach LIMIT.
// LIMIT of 0 disables expiry entirely.
module mem_timeout_ctr #(
   parameter int unsigned LIMIT = 255
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic cnt_en,
   output logic expire
);

   localparam int unsigned W = (LIMIT > 1) ? $clog2(LIMIT + 1) : 1;

   generate
      if (LIMIT == 0) begin : g_off
         logic unused_ok;
         assign unused_ok = &{1'b0, clk, reset, clr, cnt_en};
         assign expire    = 1'b0;
      end else begin : g_on
         logic [W-1:0] cnt;

         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               cnt <= '0;
            end else if (clr) begin
               cnt <= '0;
            end else if (cnt_en) begin
               cnt <= cnt + 1'b1;
            end
         end

         // Firing one short of LIMIT makes the abort edge the LIMIT-th no-ack edge.
         assign expire = cnt_en && (cnt == W'(LIMIT - 1));
      end
   endgenerate

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and data ports onto one req/ack memory; data wins unless the fetch is starved.
// Ready pulses 2 cycles after a request with an immediate ack; ports wait by holding req.
module mem_port_arbiter
   import mips_mem_pkg::*;
#(
   parameter int unsigned IF_STARVE_LIMIT = 4,
   parameter int unsigned TIMEOUT_CYCLES  = 255,
   parameter logic [31:0] ERR_DATA        = ERR_DATA_DEFAULT
) (
   input logic               clk,
   input logic               reset,
   mem_port_arbiter_if.slave bus
);

   localparam int unsigned SW = (IF_STARVE_LIMIT > 0) ? $clog2(IF_STARVE_LIMIT + 1) : 1;

   arb_state_t  state;
   arb_state_t  state_nxt;
   logic [SW-1:0] starve_cnt;

   logic        if_elig;
   logic        d_elig;
   logic        grant_if;
   logic        grant_d;
   logic        in_acc;
   logic        done;
   logic        expire;
   logic [31:0] done_rdata;
   mem_cmd_t    cmd_sel;

   // A port's req is still high during its own ready cycle and must not re-win.
   assign if_elig = bus.if_req && !bus.if_ready;
   assign d_elig  = bus.d_req && !bus.d_ready;
   assign in_acc  = (state == I_ACC) || (state == D_ACC);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      grant_if  = 1'b0;
      grant_d   = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE: begin
            if (if_elig && (starve_cnt == SW'(IF_STARVE_LIMIT))) begin
               grant_if = 1'b1;
            end else if (d_elig) begin
               grant_d = 1'b1;
            end else if (if_elig) begin
               grant_if = 1'b1;
            end
            if (grant_if) begin
               state_nxt = acc_state(PORT_IF);
            end else if (grant_d) begin
               state_nxt = acc_state(PORT_D);
            end
         end
         I_ACC, D_ACC: begin
            if (bus.mem_ack || expire) begin
               done      = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      cmd_sel = '{we: 1'b0, addr: bus.if_addr, wdata: 32'h0};
      if (grant_d) begin
         cmd_sel = '{we: bus.d_we, addr: bus.d_addr, wdata: bus.d_wdata};
      end
   end

   assign done_rdata = bus.mem_we  ? 32'h0 :
                       bus.mem_ack ? bus.mem_rdata : ERR_DATA;

   mem_timeout_ctr #(
      .LIMIT (TIMEOUT_CYCLES)
   ) u_timeout (
      .clk    (clk),
      .reset  (reset),
      .clr    (grant_if || grant_d),
      .cnt_en (in_acc && !bus.mem_ack),
      .expire (expire)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         starve_cnt    <= '0;
         bus.mem_req   <= 1'b0;
         bus.mem_we    <= 1'b0;
         bus.mem_addr  <= 32'h0;
         bus.mem_wdata <= 32'h0;
         bus.if_rdata  <= 32'h0;
         bus.if_ready  <= 1'b0;
         bus.d_rdata   <= 32'h0;
         bus.d_ready   <= 1'b0;
         bus.bus_err   <= 1'b0;
      end else begin
         bus.if_ready <= 1'b0;
         bus.d_ready  <= 1'b0;

         if (grant_if || grant_d) begin
            bus.mem_req   <= 1'b1;
            bus.mem_we    <= cmd_sel.we;
            bus.mem_addr  <= cmd_sel.addr;
            bus.mem_wdata <= cmd_sel.wdata;
         end

         if (grant_if) begin
            starve_cnt <= '0;
         end else if (grant_d && if_elig && (starve_cnt != SW'(IF_STARVE_LIMIT))) begin
            starve_cnt <= starve_cnt + 1'b1;
         end

         if (done) begin
            bus.mem_req <= 1'b0;
            if (state == I_ACC) begin
               bus.if_rdata <= done_rdata;
               bus.if_ready <= 1'b1;
            end else begin
               bus.d_rdata <= done_rdata;
               bus.d_ready <= 1'b1;
            end
            if (!bus.mem_ack) begin
               bus.bus_err <= 1'b1;
            end
         end
      end
   end

   a_ready_excl : assert property (@(posedge clk) disable iff (!reset)
      !(bus.if_ready && bus.d_ready));

   a_req_tracks_state : assert property (@(posedge clk) disable iff (!reset)
      bus.mem_req == in_acc);

   a_cmd_stable : assert property (@(posedge clk) disable iff (!reset)
      (in_acc && !done) |=> ($stable(bus.mem_addr) && $stable(bus.mem_wdata) && $stable(bus.mem_we)));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: table of single accesses plus arbitration, starvation and reset sequences.
module tb_mem_port_arbiter;
   import mips_mem_pkg::*;

   localparam int TO    = 8;
   localparam int NEVER = 1000;

   typedef struct {
      logic        is_d;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          ack_wait;
      logic [31:0] exp_rdata;
      int          exp_lat;
      logic        exp_err;
   } vec_t;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   int   n_cmp = 0;
   int   n_bad = 0;
   int   ack_wait = 0;
   int   wait_cnt = 0;
   vec_t vecs[8];

   always #5 clk = ~clk;

   mem_port_arbiter_if bus ();

   mem_port_arbiter #(
      .IF_STARVE_LIMIT (4),
      .TIMEOUT_CYCLES  (TO),
      .ERR_DATA        (32'hDEADBEEF)
   ) u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   function automatic logic [31:0] model_rd(input logic [31:0] a);
      case (a)
         32'h10:  return 32'h2002000A;
         32'h40:  return 32'h00000055;
         default: return a ^ 32'hA5A50000;
      endcase
   endfunction

   // Memory model: acks after ack_wait no-ack cycles; stores return junk read data.
   always @(negedge clk) begin
      if (bus.mem_req && (wait_cnt >= ack_wait)) begin
         bus.mem_ack   = 1'b1;
         bus.mem_rdata = bus.mem_we ? 32'hFFFFFFFF : model_rd(bus.mem_addr);
      end else begin
         bus.mem_ack   = 1'b0;
         bus.mem_rdata = 32'h0BAD0BAD;
         if (bus.mem_req) wait_cnt++;
         else             wait_cnt = 0;
      end
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   task automatic run_vec(input int idx);
      vec_t v;
      int   lat;
      logic seen;
      v        = vecs[idx];
      ack_wait = v.ack_wait;
      @(negedge clk);
      if (v.is_d) begin
         bus.d_req   = 1'b1;
         bus.d_we    = v.we;
         bus.d_addr  = v.addr;
         bus.d_wdata = v.wdata;
      end else begin
         bus.if_req  = 1'b1;
         bus.if_addr = v.addr;
      end
      lat  = 0;
      seen = 1'b0;
      while (!seen && lat < 40) begin
         @(posedge clk); #1;
         lat++;
         if (bus.mem_req) begin
            check($sformatf("v%0d_mem_addr", idx), bus.mem_addr, v.addr);
            check($sformatf("v%0d_mem_we", idx), {31'h0, bus.mem_we}, {31'h0, v.is_d & v.we});
            if (v.is_d && v.we) check($sformatf("v%0d_mem_wdata", idx), bus.mem_wdata, v.wdata);
         end
         seen = v.is_d ? bus.d_ready : bus.if_ready;
      end
      check($sformatf("v%0d_latency", idx), lat, v.exp_lat);
      check($sformatf("v%0d_rdata", idx), v.is_d ? bus.d_rdata : bus.if_rdata, v.exp_rdata);
      check($sformatf("v%0d_other_ready", idx), {31'h0, v.is_d ? bus.if_ready : bus.d_ready}, 32'h0);
      check($sformatf("v%0d_bus_err", idx), {31'h0, bus.bus_err}, {31'h0, v.exp_err});
      @(negedge clk);
      bus.if_req = 1'b0;
      bus.d_req  = 1'b0;
      @(posedge clk); #1;
      check($sformatf("v%0d_pulse_width", idx), {31'h0, bus.if_ready | bus.d_ready}, 32'h0);
   endtask

   initial begin
      int d_at;
      int i_at;
      int overlap;
      logic [31:0] d_dat;
      logic [31:0] i_dat;

      vecs[0] = '{1'b0, 1'b0, 32'h10,  32'h0,    0,     32'h2002000A, 2, 1'b0};
      vecs[1] = '{1'b1, 1'b0, 32'h40,  32'h0,    0,     32'h00000055, 2, 1'b0};
      vecs[2] = '{1'b1, 1'b1, 32'h8,   32'h1234, 3,     32'h0,        5, 1'b0};
      vecs[3] = '{1'b1, 1'b0, 32'h100, 32'h0,    2,     32'hA5A50100, 4, 1'b0};
      vecs[4] = '{1'b0, 1'b0, 32'h20,  32'h0,    7,     32'hA5A50020, 9, 1'b0};
      vecs[5] = '{1'b1, 1'b0, 32'h200, 32'h0,    NEVER, 32'hDEADBEEF, 9, 1'b1};
      vecs[6] = '{1'b0, 1'b0, 32'h44,  32'h0,    1,     32'hA5A50044, 3, 1'b1};
      vecs[7] = '{1'b1, 1'b1, 32'h300, 32'h77,   NEVER, 32'h0,        9, 1'b1};

      bus.if_req  = 1'b0;
      bus.if_addr = 32'h0;
      bus.d_req   = 1'b0;
      bus.d_we    = 1'b0;
      bus.d_addr  = 32'h0;
      bus.d_wdata = 32'h0;

      // Reset state
      #2;
      check("rst_mem_req",  {31'h0, bus.mem_req},  32'h0);
      check("rst_if_ready", {31'h0, bus.if_ready}, 32'h0);
      check("rst_d_ready",  {31'h0, bus.d_ready},  32'h0);
      check("rst_bus_err",  {31'h0, bus.bus_err},  32'h0);
      check("rst_mem_addr", bus.mem_addr, 32'h0);
      check("rst_if_rdata", bus.if_rdata, 32'h0);
      check("rst_state",    32'(u_dut.state), 32'(IDLE));
      repeat (2) @(negedge clk);
      reset = 1'b1;

      for (int i = 0; i < 8; i++) run_vec(i);

      // Simultaneous fetch and load: data first, never overlapping
      ack_wait = 0;
      @(negedge clk);
      bus.if_req = 1'b1; bus.if_addr = 32'h10;
      bus.d_req  = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h40;
      d_at = 0; i_at = 0; overlap = 0; d_dat = 32'h0; i_dat = 32'h0;
      for (int c = 1; c <= 20 && i_at == 0; c++) begin
         @(posedge clk); #1;
         if (bus.d_ready && bus.if_ready) overlap++;
         if (bus.d_ready && d_at == 0) begin d_at = c; d_dat = bus.d_rdata; end
         if (bus.if_ready && i_at == 0) begin i_at = c; i_dat = bus.if_rdata; end
         if (c == 1) check("sim_starve_after_dgrant", 32'(u_dut.starve_cnt), 32'd1);
         @(negedge clk);
         if (bus.d_ready)  bus.d_req  = 1'b0;
         if (bus.if_ready) bus.if_req = 1'b0;
      end
      check("sim_d_first_cycle",  d_at, 2);
      check("sim_if_first_cycle", i_at, 4);
      check("sim_d_rdata",  d_dat, 32'h55);
      check("sim_if_rdata", i_dat, 32'h2002000A);
      check("sim_overlap",  overlap, 0);
      check("sim_starve_cleared", 32'(u_dut.starve_cnt), 32'd0);
      bus.if_req = 1'b0; bus.d_req = 1'b0;

      // Starvation: fetch withdrawn during each data ready cycle so data keeps winning
      @(negedge clk);
      bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h60; bus.d_wdata = 32'h99;
      bus.if_addr = 32'h80;
      for (int k = 1; k <= 4; k++) begin
         bus.if_req = 1'b1;
         @(posedge clk); #1;
         check($sformatf("stv%0d_data_grant", k), bus.mem_addr, 32'h60);
         check($sformatf("stv%0d_starve", k), 32'(u_dut.starve_cnt), k);
         @(posedge clk); #1;
         check($sformatf("stv%0d_d_ready", k), {31'h0, bus.d_ready}, 32'h1);
         @(negedge clk);
         bus.if_req = 1'b0;
         @(posedge clk); #1;
         check($sformatf("stv%0d_idle_gap", k), {31'h0, bus.mem_req}, 32'h0);
         @(negedge clk);
      end
      bus.if_req = 1'b1;
      @(posedge clk); #1;
      check("stv_fetch_forced_addr", bus.mem_addr, 32'h80);
      check("stv_fetch_forced_we", {31'h0, bus.mem_we}, 32'h0);
      check("stv_starve_reset", 32'(u_dut.starve_cnt), 32'd0);
      @(posedge clk); #1;
      check("stv_if_ready", {31'h0, bus.if_ready}, 32'h1);
      check("stv_if_rdata", bus.if_rdata, 32'hA5A50080);
      @(negedge clk);
      bus.if_req = 1'b0;
      @(posedge clk); #1;
      check("stv_data_after_fetch", bus.mem_addr, 32'h60);
      check("stv_starve_hold", 32'(u_dut.starve_cnt), 32'd0);
      @(posedge clk); #1;
      check("stv_store_rdata", bus.d_rdata, 32'h0);
      @(negedge clk);
      bus.d_req = 1'b0;
      @(posedge clk); #1;

      // Reset in the middle of a data access
      ack_wait = NEVER;
      @(negedge clk);
      bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h500;
      repeat (3) @(posedge clk);
      #1;
      check("rmid_pre_mem_req", {31'h0, bus.mem_req}, 32'h1);
      check("rmid_pre_bus_err", {31'h0, bus.bus_err}, 32'h1);
      @(negedge clk);
      reset = 1'b0;
      bus.d_req = 1'b0;
      #1;
      check("rmid_mem_req_drop", {31'h0, bus.mem_req}, 32'h0);
      check("rmid_state", 32'(u_dut.state), 32'(IDLE));
      for (int c = 0; c < 5; c++) begin
         if (c == 2) begin
            @(negedge clk);
            reset = 1'b1;
         end
         @(posedge clk); #1;
         check($sformatf("rmid_no_ready%0d", c), {31'h0, bus.d_ready | bus.if_ready}, 32'h0);
      end
      check("rmid_bus_err_clear", {31'h0, bus.bus_err}, 32'h0);
      check("rmid_state_after", 32'(u_dut.state), 32'(IDLE));
      run_vec(1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
